// File: rtl/udp_rx_frame_unpack_pkg.sv
// Shared types and constants for the UDP receive frame unpacker.
package udp_rx_pkg;

  localparam logic [31:0] FRAME_HEAD_DEFAULT = 32'hF3ED7A93;
  localparam int unsigned FIFO_DEPTH_MIN     = 4;

  typedef enum logic {
    HUNT,
    PAYLOAD
  } state_e;

  // FIFO entry layout is {sof, eof, data}
  function automatic int unsigned entry_w(input int unsigned out_bytes);
    return 2 + 8 * out_bytes;
  endfunction

endpackage

// File: rtl/udp_rx_frame_unpack_if.sv
// Valid/ready word stream with start/end-of-frame markers.
interface udp_rx_frame_unpack_if #(
  parameter int unsigned OUT_BYTES = 2
) ();

  logic                   m_valid;
  logic                   m_ready;
  logic [8*OUT_BYTES-1:0] m_data;
  logic                   m_sof;
  logic                   m_eof;

  modport master (output m_valid, m_data, m_sof, m_eof, input m_ready);
  modport slave  (input m_valid, m_data, m_sof, m_eof, output m_ready);

endinterface

// File: rtl/udp_rx_frame_unpack_sync_fifo.sv
// Single-clock FIFO with show-ahead output; a push into a full FIFO is accepted only alongside a pop.
module udp_rx_sync_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/udp_rx_frame_unpack.sv
// Hunts a frame head in the UDP payload stream, packs the frame MSB-first into words
// and delivers them with sof/eof markers through an output FIFO.
module udp_rx_frame_unpack
  import udp_rx_pkg::*;
#(
  parameter logic [31:0] FRAME_HEAD = FRAME_HEAD_DEFAULT,
  parameter int unsigned HEAD_BYTES = 4,
  parameter int unsigned OUT_BYTES  = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_W      = 25
) (
  input  logic             app_rx_clk,
  input  logic             rstn,
  input  logic             app_rx_data_valid,
  input  logic [7:0]       app_rx_data,
  input  logic [LEN_W-1:0] app_rx_data_total,
  udp_rx_frame_unpack_if.master m,
  output logic             frame_err,
  output logic             overflow,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned DW    = 8 * OUT_BYTES;
  localparam int unsigned HW    = 8 * HEAD_BYTES;
  localparam int unsigned EW    = entry_w(OUT_BYTES);
  localparam int unsigned IDX_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam logic [HW-1:0] HEAD = FRAME_HEAD[HW-1:0];

  if (FIFO_DEPTH < FIFO_DEPTH_MIN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two of at least 4");
  end

  state_e           state_q, state_d;
  logic [HW-1:0]    head_q, head_d, head_next;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [DW-1:0]    pack_q, pack_d, word;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic             push_q, push_d;
  logic [EW-1:0]    push_word_q, push_word_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             last_byte;

  logic          fifo_full, fifo_empty, pop, drop;
  logic [EW-1:0] fifo_dout;

  // A simultaneous pop frees the slot, so only a push without a pop is dropped
  assign pop  = m.m_valid && m.m_ready;
  assign drop = push_q && fifo_full && !pop;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    idx_d       = idx_q;
    first_d     = first_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    frame_err_d = drop;
    overflow_d  = overflow_q | drop;
    frame_cnt_d = frame_cnt_q;
    head_next   = HW'({head_q, app_rx_data});
    last_byte   = (cnt_q + LEN_W'(1) == len_q);
    word        = pack_q;
    for (int unsigned b = 0; b < OUT_BYTES; b++) begin
      if (idx_q == IDX_W'(b)) word[DW-1-8*b -: 8] = app_rx_data;
    end

    case (state_q)
      HUNT: begin
        if (app_rx_data_valid) begin
          head_d = head_next;
          if (head_next == HEAD) begin
            head_d  = '0;
            len_d   = app_rx_data_total;
            cnt_d   = '0;
            pack_d  = '0;
            idx_d   = '0;
            first_d = 1'b1;
            if (app_rx_data_total == '0) frame_err_d = 1'b1;
            else                         state_d     = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (app_rx_data_valid) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (idx_q == IDX_W'(OUT_BYTES - 1) || last_byte) begin
            push_d      = 1'b1;
            push_word_d = {first_q, last_byte, word};
            pack_d      = '0;
            idx_d       = '0;
            first_d     = 1'b0;
          end else begin
            pack_d = word;
            idx_d  = idx_q + IDX_W'(1);
          end
          if (last_byte) begin
            state_d     = HUNT;
            head_d      = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge app_rx_clk) begin
    if (!rstn) begin
      state_q     <= HUNT;
      head_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      pack_q      <= '0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  udp_rx_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (app_rx_clk),
    .rst_n   (rstn),
    .push_i  (push_q),
    .din_i   (push_word_q),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m.m_valid                     = !fifo_empty;
  assign {m.m_sof, m.m_eof, m.m_data}  = fifo_dout;
  assign frame_err                     = frame_err_q;
  assign overflow                      = overflow_q;
  assign frame_cnt                     = frame_cnt_q;

endmodule

// File: tb/tb_udp_rx_frame_unpack.sv
// Self-checking bench: two unpackers (2- and 4-byte words) share one input byte stream.
module tb_udp_rx_frame_unpack;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vld;
  logic [7:0]  dat;
  logic [24:0] total;
  logic        fe2, ov2, fe4, ov4;
  logic [15:0] fc2, fc4;

  always #5 clk = ~clk;

  udp_rx_frame_unpack_if #(.OUT_BYTES(2)) if2 ();
  udp_rx_frame_unpack_if #(.OUT_BYTES(4)) if4 ();

  udp_rx_frame_unpack #(
    .FRAME_HEAD(32'hF3ED7A93), .HEAD_BYTES(4), .OUT_BYTES(2), .FIFO_DEPTH(16), .LEN_W(25)
  ) dut2 (
    .app_rx_clk(clk), .rstn(rstn), .app_rx_data_valid(vld), .app_rx_data(dat),
    .app_rx_data_total(total), .m(if2.master), .frame_err(fe2), .overflow(ov2), .frame_cnt(fc2)
  );

  udp_rx_frame_unpack #(
    .FRAME_HEAD(32'hF3ED7A93), .HEAD_BYTES(4), .OUT_BYTES(4), .FIFO_DEPTH(16), .LEN_W(25)
  ) dut4 (
    .app_rx_clk(clk), .rstn(rstn), .app_rx_data_valid(vld), .app_rx_data(dat),
    .app_rx_data_total(total), .m(if4.master), .frame_err(fe4), .overflow(ov4), .frame_cnt(fc4)
  );

  int errors = 0;
  int checks = 0;

  // Entries are {sof, eof, data left-aligned in 32 bits}
  logic [33:0]    obs2[$], obs4[$], exp_q[$];
  logic [7:0]     stim_b[$];
  int unsigned    stim_t[$];
  int             fe_cyc2 = 0;
  int             model_frames, model_errs;
  logic           base_rdy2 = 1'b1;
  logic           rnd_rdy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if2.m_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : base_rdy2;
    if4.m_ready = rnd_rdy ? ($urandom_range(0, 1) != 0) : 1'b1;
  end

  logic        pv2 = 1'b0, pr2 = 1'b0, prst = 1'b0;
  logic [33:0] pw2 = '0;
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (prst && pv2 && !pr2) begin
        chk("hold_valid", 64'(if2.m_valid), 64'd1);
        chk("hold_word", 64'({if2.m_sof, if2.m_eof, if2.m_data, 16'h0}), 64'(pw2));
      end
      if (if2.m_valid && if2.m_ready) obs2.push_back({if2.m_sof, if2.m_eof, if2.m_data, 16'h0});
      if (if4.m_valid && if4.m_ready) obs4.push_back({if4.m_sof, if4.m_eof, if4.m_data});
      if (fe2) fe_cyc2++;
    end
    prst = (rstn === 1'b1);
    pv2  = if2.m_valid;
    pr2  = if2.m_ready;
    pw2  = {if2.m_sof, if2.m_eof, if2.m_data, 16'h0};
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    vld = 1'b1;
    dat = b;
    stim_b.push_back(b);
    stim_t.push_back(32'(total));
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  task automatic send_head(input bit overlap);
    if (overlap) begin
      send(8'hF3);
      send(8'hED);
    end
    send(8'hF3);
    send(8'hED);
    send(8'h7A);
    send(8'h93);
  endtask

  task automatic clear_logs();
    stim_b.delete();
    stim_t.delete();
    obs2.delete();
    obs4.delete();
    fe_cyc2 = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    vld  = 1'b0;
    idle(2);
    rstn = 1'b1;
    clear_logs();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 400 && !(k >= 3 && !if2.m_valid && !if4.m_valid)) begin
      idle(1);
      k++;
    end
    chk("drain_timeout", 64'(k < 400), 64'd1);
  endtask

  // Reference: scan the recorded byte stream for heads, cut frames, split into padded words.
  task automatic run_model(input int unsigned ob);
    logic [7:0]  hist[$];
    logic [7:0]  fr[$];
    int unsigned rem, nw;
    logic [31:0] w;
    exp_q.delete();
    model_frames = 0;
    model_errs   = 0;
    rem          = 0;
    foreach (stim_b[i]) begin
      if (rem == 0) begin
        hist.push_back(stim_b[i]);
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4 && hist[0] == 8'hF3 && hist[1] == 8'hED &&
            hist[2] == 8'h7A && hist[3] == 8'h93) begin
          hist.delete();
          if (stim_t[i] == 0) model_errs++;
          else begin
            rem = stim_t[i];
            fr.delete();
          end
        end
      end else begin
        fr.push_back(stim_b[i]);
        rem--;
        if (rem == 0) begin
          model_frames++;
          nw = (fr.size() + ob - 1) / ob;
          for (int unsigned wi = 0; wi < nw; wi++) begin
            w = '0;
            for (int unsigned k = 0; k < ob; k++)
              if (wi * ob + k < fr.size()) w[31-8*k -: 8] = fr[wi*ob+k];
            exp_q.push_back({wi == 0, wi == nw - 1, w});
          end
        end
      end
    end
  endtask

  task automatic cmp_model(input string nm, input int unsigned ob);
    logic [33:0] obs[$];
    run_model(ob);
    if (ob == 2) obs = obs2;
    else         obs = obs4;
    chk({nm, "_count"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      chk({nm, "_word"}, 64'(obs[i]), 64'(exp_q[i]));
  endtask

  typedef struct {
    logic [24:0] total;
    bit          overlap;
    logic [7:0]  base;
    logic [7:0]  step;
    int unsigned n2;
    logic [33:0] f2, l2;
    int unsigned n4;
    logic [33:0] f4, l4;
  } vec_t;

  vec_t vt[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b;
    int          n;
    logic [33:0] e;

    vt[0] = '{25'd5, 1'b0, 8'hAA, 8'h11, 3, {2'b10, 32'hAABB0000}, {2'b01, 32'hEE000000},
              2, {2'b10, 32'hAABBCCDD}, {2'b01, 32'hEE000000}};
    vt[1] = '{25'd2, 1'b1, 8'h11, 8'h11, 1, {2'b11, 32'h11220000}, {2'b11, 32'h11220000},
              1, {2'b11, 32'h11220000}, {2'b11, 32'h11220000}};
    vt[2] = '{25'd1, 1'b0, 8'h5A, 8'h00, 1, {2'b11, 32'h5A000000}, {2'b11, 32'h5A000000},
              1, {2'b11, 32'h5A000000}, {2'b11, 32'h5A000000}};
    vt[3] = '{25'd3, 1'b0, 8'hA0, 8'h01, 2, {2'b10, 32'hA0A10000}, {2'b01, 32'hA2000000},
              1, {2'b11, 32'hA0A1A200}, {2'b11, 32'hA0A1A200}};
    vt[4] = '{25'd8, 1'b0, 8'h10, 8'h01, 4, {2'b10, 32'h10110000}, {2'b01, 32'h16170000},
              2, {2'b10, 32'h10111213}, {2'b01, 32'h14151617}};

    rstn  = 1'b0;
    vld   = 1'b0;
    dat   = '0;
    total = '0;
    do_reset();
    @(negedge clk);
    chk("rst_valid", 64'(if2.m_valid), 64'd0);
    chk("rst_data", 64'(if2.m_data), 64'd0);
    chk("rst_sof_eof", 64'({if2.m_sof, if2.m_eof}), 64'd0);
    chk("rst_err_ovf", 64'({fe2, ov2}), 64'd0);
    chk("rst_frame_cnt", 64'(fc2), 64'd0);
    @(posedge clk);
    #1;

    // Directed frames from the table
    foreach (vt[r]) begin
      do_reset();
      total = vt[r].total;
      send(8'h55);
      send_head(vt[r].overlap);
      for (int i = 0; i < int'(vt[r].total); i++) send(8'(vt[r].base + 8'(i) * vt[r].step));
      drain();
      chk("tbl_n2", 64'(obs2.size()), 64'(vt[r].n2));
      if (obs2.size() > 0) begin
        chk("tbl_first2", 64'(obs2[0]), 64'(vt[r].f2));
        chk("tbl_last2", 64'(obs2[obs2.size()-1]), 64'(vt[r].l2));
      end
      chk("tbl_n4", 64'(obs4.size()), 64'(vt[r].n4));
      if (obs4.size() > 0) begin
        chk("tbl_first4", 64'(obs4[0]), 64'(vt[r].f4));
        chk("tbl_last4", 64'(obs4[obs4.size()-1]), 64'(vt[r].l4));
      end
      chk("tbl_frame_cnt", 64'(fc2), 64'd1);
      chk("tbl_no_err", 64'(fe_cyc2), 64'd0);
    end

    // 54-byte frame behind a preamble, valid dropping for 20 cycles after every 9 bytes
    do_reset();
    total = 25'd54;
    n = 0;
    for (int i = 0; i < 61; i++) begin
      if (i < 3)      b = 8'(i + 1);
      else if (i < 7) begin
        case (i)
          3:       b = 8'hF3;
          4:       b = 8'hED;
          5:       b = 8'h7A;
          default: b = 8'h93;
        endcase
      end else        b = 8'(i - 7);
      send(b);
      n++;
      if (n % 9 == 0) idle(20);
    end
    drain();
    chk("f54_count", 64'(obs2.size()), 64'd27);
    for (int i = 0; i < 27 && i < obs2.size(); i++) begin
      e = {i == 0, i == 26, 8'(2 * i), 8'(2 * i + 1), 16'h0};
      chk("f54_word", 64'(obs2[i]), 64'(e));
    end
    chk("f54_frame_cnt", 64'(fc2), 64'd1);
    cmp_model("f54_w4", 4);

    // Zero-length head, then a 2-byte frame with minimum latency
    do_reset();
    total = '0;
    send_head(1'b0);
    total = 25'd2;
    send_head(1'b0);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    chk("lat_not_yet", 64'(if2.m_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(if2.m_valid), 64'd1);
    chk("lat_word", 64'({if2.m_sof, if2.m_eof, if2.m_data}), 64'({2'b11, 16'h1122}));
    @(posedge clk);
    #1;
    drain();
    chk("zl_err_cycles", 64'(fe_cyc2), 64'd1);
    chk("zl_words", 64'(obs2.size()), 64'd1);
    chk("zl_frame_cnt", 64'(fc2), 64'd1);

    // Overflow with consumer stalled
    base_rdy2 = 1'b0;
    do_reset();
    total = 25'd54;
    send_head(1'b0);
    for (int i = 0; i < 54; i++) send(8'(i));
    idle(6);
    chk("ovf_err_cycles", 64'(fe_cyc2), 64'd11);
    chk("ovf_sticky", 64'(ov2), 64'd1);
    chk("ovf_frame_cnt", 64'(fc2), 64'd1);
    chk("ovf_head_word", 64'({if2.m_valid, if2.m_sof, if2.m_eof, if2.m_data}), 64'({3'b110, 16'h0001}));
    base_rdy2 = 1'b1;
    drain();
    chk("ovf_drained", 64'(obs2.size()), 64'd16);
    for (int i = 0; i < 16 && i < obs2.size(); i++) begin
      e = {i == 0, 1'b0, 8'(2 * i), 8'(2 * i + 1), 16'h0};
      chk("ovf_word", 64'(obs2[i]), 64'(e));
    end
    chk("ovf_still_set", 64'(ov2), 64'd1);

    // Reset mid-payload, then a fresh frame
    total = 25'd20;
    send_head(1'b0);
    for (int i = 0; i < 7; i++) send(8'(i));
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(if2.m_valid), 64'd0);
    chk("mid_rst_data", 64'({if2.m_sof, if2.m_eof, if2.m_data}), 64'd0);
    chk("mid_rst_flags", 64'({fe2, ov2}), 64'd0);
    chk("mid_rst_frame_cnt", 64'(fc2), 64'd0);
    @(posedge clk);
    #1;
    clear_logs();
    total = 25'd9;
    send_head(1'b0);
    for (int i = 0; i < 9; i++) send(8'($urandom));
    drain();
    cmp_model("post_rst_w2", 2);
    cmp_model("post_rst_w4", 4);
    chk("post_rst_frame_cnt", 64'(fc2), 64'd1);

    // Random frames, junk, gaps and backpressure against the reference model
    do_reset();
    rnd_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 3)) send(8'($urandom));
      total = (f % 6 == 2) ? '0 : 25'($urandom_range(1, 23));
      send_head(f % 5 == 1);
      repeat (int'(total)) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(8'($urandom));
      end
    end
    rnd_rdy = 1'b0;
    idle(2);
    drain();
    cmp_model("rnd_w2", 2);
    chk("rnd_frame_cnt", 64'(fc2), 64'(16'(model_frames)));
    chk("rnd_err_cycles", 64'(fe_cyc2), 64'(model_errs));
    chk("rnd_no_ovf", 64'(ov2), 64'd0);
    cmp_model("rnd_w4", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
